// File: rtl/music_control_pkg.sv
// Shared types and constants for the music_control record/playback sequencer.
// Holds the FSM state enumeration, the slot count and the default tick lengths.
package music_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RECORD,
    FETCH,
    HOLD
  } state_t;

  localparam int NUM_SLOTS = 16;
  localparam int SLOT_W    = 4;

  localparam int unsigned NOTE_TICKS_DEF  = 12_500_000;
  localparam int unsigned CLEAR_TICKS_DEF = 19_200;
  localparam int unsigned FETCH_TICKS_DEF = 2;

endpackage

// File: rtl/music_control_key_edge.sv
// key_edge: rising-edge detector for one synchronized button/level input.
// Ports: clk, reset (sync, active-high), level in; rise out (one-cycle event).
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;
  logic armed;

  // armed stays low for the first cycle after reset, so a level
  // held through reset release only loads history, never fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= level;
      armed <= 1'b1;
    end
  end

  assign rise = armed & level & ~prev;

endmodule

// File: rtl/music_control.sv
// music_control: record/playback sequencer FSM for a 16-slot note memory.
// Ports: clk, reset (sync, active-high); rec_btn, play_btn, stop_btn,
//   clear_btn, note_valid in; ld_note, ld_play, note_counter[3:0], clear,
//   display_note, mute, busy out.
// Build option: define LOOP_PLAY_EN to loop playback after slot 15;
//   otherwise playback stops in IDLE after the last slot.
module music_control
  import music_pkg::*;
#(
  parameter int unsigned NOTE_TICKS  = NOTE_TICKS_DEF,
  parameter int unsigned CLEAR_TICKS = CLEAR_TICKS_DEF,
  parameter int unsigned FETCH_TICKS = FETCH_TICKS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_btn,
  input  logic              play_btn,
  input  logic              stop_btn,
  input  logic              clear_btn,
  input  logic              note_valid,
  output logic              ld_note,
  output logic              ld_play,
  output logic [SLOT_W-1:0] note_counter,
  output logic              clear,
  output logic              display_note,
  output logic              mute,
  output logic              busy
);

  localparam logic [31:0] CLR_LAST = 32'(CLEAR_TICKS - 1);
  localparam logic [31:0] FET_LAST = 32'(FETCH_TICKS - 1);
  localparam logic [31:0] NOT_LAST = 32'(NOTE_TICKS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);

  state_t state, state_d;
  logic [31:0] tick, tick_d;
  logic [SLOT_W-1:0] slot_d;
  logic [SLOT_W-1:0] wcnt, wcnt_d;
  logic ld_note_d;

  logic rec_ev, play_ev, stop_ev, clear_ev, nv_ev;
  logic stop_hit, clear_hit, play_hit, rec_hit;

  key_edge u_rec (
    .clk(clk), .reset(reset), .level(rec_btn), .rise(rec_ev)
  );
  key_edge u_play (
    .clk(clk), .reset(reset), .level(play_btn), .rise(play_ev)
  );
  key_edge u_stop (
    .clk(clk), .reset(reset), .level(stop_btn), .rise(stop_ev)
  );
  key_edge u_clear (
    .clk(clk), .reset(reset), .level(clear_btn), .rise(clear_ev)
  );
  key_edge u_note (
    .clk(clk), .reset(reset), .level(note_valid), .rise(nv_ev)
  );

  // One winner per cycle: stop > clear > play > rec.
  assign stop_hit  = stop_ev;
  assign clear_hit = clear_ev & ~stop_ev;
  assign play_hit  = play_ev & ~stop_ev & ~clear_ev;
  assign rec_hit   = rec_ev & ~stop_ev & ~clear_ev & ~play_ev;

  always_comb begin
    state_d   = state;
    slot_d    = note_counter;
    wcnt_d    = wcnt;
    ld_note_d = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          clear_hit: state_d = CLEAR;
          play_hit:  state_d = FETCH;
          rec_hit:   state_d = RECORD;
          default:   state_d = IDLE;
        endcase
      end
      CLEAR: begin
        if (tick == CLR_LAST) state_d = IDLE;
      end
      RECORD: begin
        if (stop_hit) begin
          state_d = IDLE;
        end else if (nv_ev) begin
          ld_note_d = 1'b1;
          wcnt_d    = wcnt + 1'b1;
          if (wcnt == SLOT_LAST) state_d = IDLE;
        end
      end
      FETCH: begin
        if (stop_hit)             state_d = IDLE;
        else if (clear_hit)       state_d = CLEAR;
        else if (tick == FET_LAST) state_d = HOLD;
      end
      HOLD: begin
        if (stop_hit) begin
          state_d = IDLE;
        end else if (clear_hit) begin
          state_d = CLEAR;
        end else if (tick == NOT_LAST) begin
          slot_d  = note_counter + 1'b1;
          state_d = FETCH;
`ifdef LOOP_PLAY_EN
`else
          if (note_counter == SLOT_LAST) state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != RECORD) wcnt_d = '0;
    if (state_d == IDLE || state_d == CLEAR) slot_d = '0;
    // Tick counter restarts on every state entry.
    tick_d = (state_d != state) ? 32'd0 : tick + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tick         <= '0;
      note_counter <= '0;
      wcnt         <= '0;
      ld_note      <= 1'b0;
    end else begin
      state        <= state_d;
      tick         <= tick_d;
      note_counter <= slot_d;
      wcnt         <= wcnt_d;
      ld_note      <= ld_note_d;
    end
  end

  assign ld_play      = (state == FETCH) || (state == HOLD);
  assign clear        = (state == CLEAR);
  assign display_note = (state == RECORD);
  assign mute         = (state != HOLD);
  assign busy         = (state != IDLE);

endmodule
